// File: rtl/mux_switch_sequencer.sv
// mux_switch_sequencer: drives the design mux control lines so that a design
// switch happens with both designs held in reset while the new select is
// clocked through the mux's conf-clock synchroniser.
module mux_switch_sequencer #(
   parameter int unsigned RST_PRE     = 4,
   parameter int unsigned CONF_PULSES = 3,
   parameter int unsigned RST_POST    = 8,
   parameter logic [3:0]  RESET_SEL   = 4'd15,
   parameter logic [15:0] LEGAL_MASK  = 16'h780F
) (
   input  logic       wb_clk_i,
   input  logic       rst_n,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [3:0] i_req_sel,
   input  logic       i_sys_reset_enb,
   input  logic       i_auto_reset_enb,
   input  logic [7:0] i_design_reset,
   output logic [3:0] o_mux_sel,
   output logic       o_mux_conf_clk,
   output logic       o_mux_sys_reset_enb,
   output logic       o_mux_auto_reset_enb,
   output logic [7:0] o_design_reset,
   output logic [3:0] o_cur_sel,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err
);

   localparam logic [7:0] PRE_LEN  = 8'(RST_PRE - 1);
   localparam logic [7:0] CONF_LEN = 8'(2 * CONF_PULSES - 1);
   localparam logic [7:0] POST_LEN = 8'(RST_POST - 1);
   // The reset cycle itself precedes the INIT burst, so the counter starts
   // one higher to give exactly 2*CONF_PULSES burst cycles after release.
   localparam logic [7:0] INIT_LEN = 8'(2 * CONF_PULSES);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_PRE_RST,
      S_CONF,
      S_POST_RST,
      S_DONE
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] seq_rst, seq_rst_nxt;
   logic [3:0] new_sel, new_sel_nxt;
   logic [3:0] sel_nxt;
   logic       conf_nxt;
   logic       done_nxt;
   logic       err_nxt;

   // Ids 8-15 have no per-design reset line.
   function automatic logic [7:0] rst_bit(input logic [3:0] id);
      logic [7:0] b;
      b = 8'h00;
      if (!id[3]) b[id[2:0]] = 1'b1;
      return b;
   endfunction

   // Next-state and next-output decode.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      seq_rst_nxt = seq_rst;
      new_sel_nxt = new_sel;
      sel_nxt     = o_mux_sel;
      conf_nxt    = 1'b0;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         S_INIT: begin
            if (cnt == 8'd0) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt  = cnt - 8'd1;
               conf_nxt = cnt_nxt[0];
            end
         end
         S_IDLE: begin
            if (i_req_valid && o_req_ready) begin
               if (LEGAL_MASK[i_req_sel]) begin
                  state_nxt   = S_PRE_RST;
                  cnt_nxt     = PRE_LEN;
                  new_sel_nxt = i_req_sel;
                  seq_rst_nxt = rst_bit(o_cur_sel) | rst_bit(i_req_sel);
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_PRE_RST: begin
            if (cnt == 8'd0) begin
               // Select changes on CONF entry with conf_clk low, so the first
               // rising edge comes one cycle after the select is stable.
               state_nxt = S_CONF;
               cnt_nxt   = CONF_LEN;
               sel_nxt   = new_sel;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_CONF: begin
            if (cnt == 8'd0) begin
               state_nxt = S_POST_RST;
               cnt_nxt   = POST_LEN;
            end else begin
               cnt_nxt  = cnt - 8'd1;
               conf_nxt = ~cnt_nxt[0];
            end
         end
         S_POST_RST: begin
            if (cnt == 8'd0) begin
               state_nxt   = S_DONE;
               seq_rst_nxt = 8'h00;
               done_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_INIT;
         end
      endcase
   end

   // State, counter and all registered outputs.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state                <= S_INIT;
         cnt                  <= INIT_LEN;
         seq_rst              <= 8'h00;
         new_sel              <= RESET_SEL;
         o_mux_sel            <= RESET_SEL;
         o_cur_sel            <= RESET_SEL;
         o_mux_conf_clk       <= 1'b0;
         o_mux_sys_reset_enb  <= 1'b1;
         o_mux_auto_reset_enb <= 1'b1;
         o_design_reset       <= 8'h00;
         o_req_ready          <= 1'b0;
         o_busy               <= 1'b1;
         o_done               <= 1'b0;
         o_err                <= 1'b0;
      end else begin
         state                <= state_nxt;
         cnt                  <= cnt_nxt;
         seq_rst              <= seq_rst_nxt;
         new_sel              <= new_sel_nxt;
         o_mux_sel            <= sel_nxt;
         o_cur_sel            <= sel_nxt;
         o_mux_conf_clk       <= conf_nxt;
         o_mux_sys_reset_enb  <= i_sys_reset_enb;
         o_mux_auto_reset_enb <= i_auto_reset_enb;
         o_design_reset       <= seq_rst_nxt | i_design_reset;
         o_req_ready          <= (state_nxt == S_IDLE);
         o_busy               <= (state_nxt != S_IDLE);
         o_done               <= done_nxt;
         o_err                <= err_nxt;
      end
   end

endmodule
